// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-byte holding register.
//
// A byte offered on tx_valid/tx_data is accepted into the holding register
// whenever it is empty (tx_ready high). The FSM moves the held byte into the
// shift register as soon as it is idle or has just finished a stop bit. A
// byte queued during a frame therefore follows that frame with no idle gap.
//
// Ports:
//   sys_clk  - single clock, rising-edge active
//   rst      - asynchronous, active-high reset
//   tx_valid - tx_data holds a byte to send
//   tx_data  - payload byte, sampled only on acceptance
//   tx_ready - holding register empty, a byte can be accepted
//   tx       - serial line (idle high, start bit, 8 data bits LSB first, stop bit)
//   busy     - FSM is not idle
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             tx_q, tx_d;
  logic             accept;
  logic             bit_end;

  // Acceptance needs an empty holding register and emptying needs a full one,
  // so a load and an unload can never coincide on the same edge.
  assign accept  = tx_valid && !hold_full_q;
  assign bit_end = (cnt_q == CNT_MAX);

  // State register: control state is reset asynchronously
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
    end
  end

  // Payload registers carry no reset; they are qualified by hold_full_q / state
  always_ff @(posedge sys_clk) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = START;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          idx_d = '0;
          // A queued byte starts the next frame straight out of the stop bit
          if (hold_full_q) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: line level for the upcoming state, registered into tx_q
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = !hold_full_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz, SHALL set bit timing together with BAUD.
REQ-002 Parameter BAUD, default 115200, serial bit rate, SHALL give BIT_CNT = CLK_FREQ/BAUD (integer division; 434 at defaults).
REQ-003 sys_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 tx_valid  input  1  SHALL indicate tx_data holds a byte to send.
REQ-006 tx_data  input  8  SHALL carry the payload byte, sampled only on acceptance.
REQ-007 tx_ready  output  1  SHALL be high when the holding register is empty and a byte can be accepted.
REQ-008 tx  output  1  SHALL be the serial line: idle high, 8N1 framing, LSB first.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-010 Acceptance SHALL occur on a rising edge where tx_valid && tx_ready; tx_data SHALL be copied into a one-byte holding register and tx_ready SHALL go low on that edge.
REQ-011 tx_valid while tx_ready is low SHALL be ignored; the held byte SHALL NOT be overwritten.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE -> START SHALL occur on the first edge on which the holding register is full; on that edge the byte SHALL move to the shift register, the holding register SHALL empty (tx_ready high), and tx SHALL drive 0.
REQ-014 Latency: start bit SHALL appear on tx exactly one clock after the accepting edge when the FSM was IDLE.
REQ-015 A baud counter SHALL count 0..BIT_CNT-1; every bit (start, each data bit, stop) SHALL last exactly BIT_CNT clocks.
REQ-016 START -> DATA after BIT_CNT clocks; DATA SHALL output bits 0..7 in order, a 3-bit index advancing at each counter wrap; DATA -> STOP after bit 7 completes.
REQ-017 STOP SHALL drive tx=1 for BIT_CNT clocks; at its end, if the holding register is full, SHALL go directly to START (no idle gap, back-to-back frame), else SHALL go to IDLE.
REQ-018 A byte accepted during any frame SHALL be transmitted immediately after that frame; total frame length SHALL be exactly 10*BIT_CNT clocks.
REQ-019 Acceptance on the same edge the FSM empties the holding register (IDLE->START or STOP->START) SHALL be impossible because tx_ready was low that cycle; no byte SHALL be lost or duplicated.
REQ-020 tx SHALL be driven from a register (glitch-free, no combinational path from tx_data/tx_valid).
REQ-021 tx_valid/tx_data changes outside acceptance SHALL NOT affect the frame in flight.

Reset
REQ-022 Asserting rst SHALL, without waiting for a clock edge, force: FSM=IDLE, tx=1, tx_ready=1, busy=0, baud counter=0, bit index=0, holding register empty.
REQ-023 Reset mid-frame SHALL abort the frame immediately (tx high); the held byte SHALL be discarded.
REQ-024 After rst deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-025 Reset then idle 1000 clocks, tx_valid=0 -> tx=1, tx_ready=1, busy=0 throughout.
REQ-026 Send 0x58 from IDLE at defaults -> start bit one clock after acceptance, then tx = 0,0,0,1,1,0,1,0 each 434 clocks, stop 434 clocks high, busy low after 4340 clocks.
REQ-027 Send 0x00 then 0xBD with tx_valid held high -> second accepted right after first start bit begins, two frames contiguous (8680 clocks, no idle gap), receiver model decodes 0x00, 0xBD.
REQ-028 Hold tx_valid with changing tx_data while tx_ready=0 -> only the value present at acceptance is transmitted; no extra frame.
REQ-029 Assert rst during data bit 3 of 0x0F -> tx=1 before next clock edge, tx_ready=1, busy=0; a following send of 0x07 is framed correctly.
REQ-030 Sequence 0x00,0x07,0x0F,0x58,0x04,0x3E,0x4E,0xBD looped back into the team's RX block -> RX valid_flag pulses 8 times with identical data_out values in order.
